// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and byte width.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_LAUNCH    = 2'd1,
        ARB_WAIT_RISE = 2'd2,
        ARB_WAIT_FALL = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin chooser: first set request strictly after ptr, with wrap.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] winner_idx
);

    int   cand;
    logic found;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = 0;
        // Last-served requester (ptr) is visited last, which gives the rotation.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!found && req[IDX_W'(cand)]) begin
                found                 = 1'b1;
                winner[IDX_W'(cand)]  = 1'b1;
                winner_idx            = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx serializer among N_REQ byte requesters.
// Optional launch watchdog enabled by defining UART_ARB_WDOG_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int WDOG_CYCLES = 16
) (
    input  logic                         uart_clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [UART_DATA_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]             grant,
    output logic [N_REQ-1:0]             ack,
    output logic                         tx_pos,
    output logic [UART_DATA_W-1:0]       tx_data,
    input  logic                         tx_busy,
    output logic                         arb_err
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t             state, state_nxt;
    logic [IDX_W-1:0]       ptr, ptr_nxt;
    logic [N_REQ-1:0]       grant_nxt, ack_nxt;
    logic                   tx_pos_nxt;
    logic [UART_DATA_W-1:0] tx_data_nxt, pick_byte;
    logic [N_REQ-1:0]       pick_onehot;
    logic [IDX_W-1:0]       pick_idx;

`ifdef UART_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_cnt, wdog_cnt_nxt;
    logic              arb_err_q, arb_err_nxt;
    assign arb_err = arb_err_q;
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES != 0);
    assign arb_err     = 1'b0;
`endif

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req        (req),
        .ptr        (ptr),
        .winner     (pick_onehot),
        .winner_idx (pick_idx)
    );

    always_comb begin
        pick_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) pick_byte = req_data[i*UART_DATA_W +: UART_DATA_W];
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        grant_nxt   = grant;
        ack_nxt     = '0;
        tx_pos_nxt  = tx_pos;
        tx_data_nxt = tx_data;
`ifdef UART_ARB_WDOG_EN
        wdog_cnt_nxt = wdog_cnt;
        arb_err_nxt  = arb_err_q;
`endif
        case (state)
            ARB_IDLE: begin
                // A busy serializer here belongs to someone else; leave it alone.
                if (|req && !tx_busy) begin
                    grant_nxt   = pick_onehot;
                    tx_data_nxt = pick_byte;
                    ptr_nxt     = pick_idx;
                    tx_pos_nxt  = 1'b1;
                    state_nxt   = ARB_LAUNCH;
`ifdef UART_ARB_WDOG_EN
                    wdog_cnt_nxt = '0;
`endif
                end
            end
            ARB_LAUNCH: begin
                state_nxt = ARB_WAIT_RISE;
`ifdef UART_ARB_WDOG_EN
                wdog_cnt_nxt = wdog_cnt + WDOG_W'(1);
`endif
            end
            ARB_WAIT_RISE: begin
                if (tx_busy) begin
                    tx_pos_nxt = 1'b0;
                    state_nxt  = ARB_WAIT_FALL;
                end
`ifdef UART_ARB_WDOG_EN
                else if (wdog_cnt >= WDOG_W'(WDOG_CYCLES - 1)) begin
                    tx_pos_nxt  = 1'b0;
                    ack_nxt     = grant;
                    grant_nxt   = '0;
                    arb_err_nxt = 1'b1;
                    state_nxt   = ARB_IDLE;
                end else begin
                    wdog_cnt_nxt = wdog_cnt + WDOG_W'(1);
                end
`endif
            end
            ARB_WAIT_FALL: begin
                if (!tx_busy) begin
                    ack_nxt   = grant;
                    grant_nxt = '0;
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge uart_clk) begin
        if (!rst) begin
            state   <= ARB_IDLE;
            ptr     <= IDX_W'(N_REQ - 1);
            grant   <= '0;
            ack     <= '0;
            tx_pos  <= 1'b0;
            tx_data <= '0;
`ifdef UART_ARB_WDOG_EN
            wdog_cnt  <= '0;
            arb_err_q <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            grant   <= grant_nxt;
            ack     <= ack_nxt;
            tx_pos  <= tx_pos_nxt;
            tx_data <= tx_data_nxt;
`ifdef UART_ARB_WDOG_EN
            wdog_cnt  <= wdog_cnt_nxt;
            arb_err_q <= arb_err_nxt;
`endif
        end
    end

endmodule
